flip_sequencer: RTL and testbench

//  Game-flow controller for the 16-card memory board. Accepts card selections

---
 rtl/flip_sequencer_if.sv | 25 ++
 rtl/flip_sequencer.sv | 131 +++++++++++++
 tb/tb_flip_sequencer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/flip_sequencer_if.sv
// rtl/flip_sequencer_if.sv - Selection/board-state bundle between game front-end and flip_sequencer
interface flip_sequencer_if;
    logic        restart;
    logic        sel;
    logic [3:0]  sel_idx;
    logic [47:0] memory_flat;
    logic        time_over;
    logic [15:0] flip;
    logic [15:0] matched;
    logic [3:0]  ccount;
    logic [3:0]  wcount;
    logic        busy;
    logic        game_win;
    logic        game_over;

    modport master (
        output restart, sel, sel_idx, memory_flat, time_over,
        input  flip, matched, ccount, wcount, busy, game_win, game_over
    );

    modport slave (
        input  restart, sel, sel_idx, memory_flat, time_over,
        output flip, matched, ccount, wcount, busy, game_win, game_over
    );
endinterface

// File: rtl/flip_sequencer.sv
// rtl/flip_sequencer.sv - Memory-game flow FSM: two-card reveal, hold, compare; option WRONG_LIMIT_EN
module flip_sequencer #(
    parameter int HOLD_CYCLES = 25_000_000,
    parameter int HOLD_W      = 25,
    parameter int MAX_WRONG   = 10
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    flip_sequencer_if.slave   bus
);
    typedef enum logic [2:0] {
        ST_FIRST,
        ST_SECOND,
        ST_SHOW,
        ST_RESOLVE,
        ST_DONE
    } state_t;

`ifdef WRONG_LIMIT_EN
    localparam bit WrongLimitEn = 1'b1;
`else
    localparam bit WrongLimitEn = 1'b0;
`endif
    localparam logic [HOLD_W-1:0] HoldLast = HOLD_W'(HOLD_CYCLES - 1);

    state_t            state_q;
    logic [HOLD_W-1:0] cnt_q;
    logic [3:0]        first_idx_q, second_idx_q;
    logic [15:0]       flip_q, matched_q;
    logic [3:0]        ccount_q, wcount_q;
    logic              busy_q, game_win_q, game_over_q;

    logic              sel_valid_d;
    logic [5:0]        off_a_d, off_b_d;
    logic              pair_eq_d;
    logic [15:0]       pair_mask_d;
    logic [3:0]        wcount_d;

    assign sel_valid_d = bus.sel && !flip_q[bus.sel_idx];
    assign off_a_d     = 6'(first_idx_q) * 6'd3;
    assign off_b_d     = 6'(second_idx_q) * 6'd3;
    assign pair_eq_d   = bus.memory_flat[off_a_d +: 3] == bus.memory_flat[off_b_d +: 3];
    assign pair_mask_d = (16'd1 << first_idx_q) | (16'd1 << second_idx_q);
    assign wcount_d    = (wcount_q == 4'hF) ? 4'hF : wcount_q + 4'd1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_FIRST;
            cnt_q        <= '0;
            first_idx_q  <= '0;
            second_idx_q <= '0;
            flip_q       <= '0;
            matched_q    <= '0;
            ccount_q     <= '0;
            wcount_q     <= '0;
            busy_q       <= 1'b0;
            game_win_q   <= 1'b0;
            game_over_q  <= 1'b0;
        end else if (bus.restart) begin
            state_q      <= ST_FIRST;
            cnt_q        <= '0;
            first_idx_q  <= '0;
            second_idx_q <= '0;
            flip_q       <= '0;
            matched_q    <= '0;
            ccount_q     <= '0;
            wcount_q     <= '0;
            busy_q       <= 1'b0;
            game_win_q   <= 1'b0;
            game_over_q  <= 1'b0;
        end else if (bus.time_over && state_q != ST_DONE) begin
            // Time-out abandons any pending pair unscored.
            state_q     <= ST_DONE;
            flip_q      <= matched_q;
            busy_q      <= 1'b0;
            game_over_q <= 1'b1;
        end else begin
            case (state_q)
                ST_FIRST: if (sel_valid_d) begin
                    flip_q[bus.sel_idx] <= 1'b1;
                    first_idx_q         <= bus.sel_idx;
                    state_q             <= ST_SECOND;
                end
                ST_SECOND: if (sel_valid_d) begin
                    flip_q[bus.sel_idx] <= 1'b1;
                    second_idx_q        <= bus.sel_idx;
                    cnt_q               <= '0;
                    busy_q              <= 1'b1;
                    state_q             <= ST_SHOW;
                end
                ST_SHOW: begin
                    if (cnt_q == HoldLast) state_q <= ST_RESOLVE;
                    else                   cnt_q   <= cnt_q + 1'b1;
                end
                ST_RESOLVE: begin
                    busy_q <= 1'b0;
                    if (pair_eq_d) begin
                        matched_q <= matched_q | pair_mask_d;
                        ccount_q  <= ccount_q + 4'd1;
                        if (ccount_q == 4'd7) begin
                            state_q     <= ST_DONE;
                            game_win_q  <= 1'b1;
                            game_over_q <= 1'b1;
                        end else begin
                            state_q <= ST_FIRST;
                        end
                    end else begin
                        flip_q   <= flip_q & ~pair_mask_d;
                        wcount_q <= wcount_d;
                        if (WrongLimitEn && wcount_d == 4'(MAX_WRONG)) begin
                            state_q     <= ST_DONE;
                            game_over_q <= 1'b1;
                        end else begin
                            state_q <= ST_FIRST;
                        end
                    end
                end
                ST_DONE:  flip_q  <= matched_q;
                default:  state_q <= ST_FIRST;
            endcase
        end
    end

    assign bus.flip      = flip_q;
    assign bus.matched   = matched_q;
    assign bus.ccount    = ccount_q;
    assign bus.wcount    = wcount_q;
    assign bus.busy      = busy_q;
    assign bus.game_win  = game_win_q;
    assign bus.game_over = game_over_q;
endmodule

// File: tb/tb_flip_sequencer.sv
// tb/tb_flip_sequencer.sv - Directed self-checking bench for flip_sequencer (HOLD_CYCLES=4, MAX_WRONG=2)
module tb_flip_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
`ifdef WRONG_LIMIT_EN
    localparam bit LimitEn = 1'b1;
`else
    localparam bit LimitEn = 1'b0;
`endif

    flip_sequencer_if bus ();

    flip_sequencer #(.HOLD_CYCLES(4), .HOLD_W(3), .MAX_WRONG(2)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_sel(input logic [3:0] idx);
        @(negedge clk);
        bus.sel     = 1'b1;
        bus.sel_idx = idx;
        @(negedge clk);
        bus.sel     = 1'b0;
    endtask

    task automatic pulse_restart();
        @(negedge clk);
        bus.restart = 1'b1;
        @(negedge clk);
        bus.restart = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        logic [2:0] sym [16] = '{3'd2, 3'd1, 3'd4, 3'd1, 3'd4, 3'd2, 3'd0, 3'd0,
                                 3'd3, 3'd3, 3'd5, 3'd5, 3'd6, 3'd6, 3'd7, 3'd7};
        logic [3:0] pa [8] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd8, 4'd10, 4'd12, 4'd14};
        logic [3:0] pb [8] = '{4'd5, 4'd3, 4'd4, 4'd7, 4'd9, 4'd11, 4'd13, 4'd15};
        int busy_cycles;

        bus.restart   = 1'b0;
        bus.sel       = 1'b0;
        bus.sel_idx   = '0;
        bus.time_over = 1'b0;
        for (int i = 0; i < 16; i++) bus.memory_flat[3*i +: 3] = sym[i];

        repeat (3) @(negedge clk);
        check("rst_flip",      32'(bus.flip),      32'h0);
        check("rst_matched",   32'(bus.matched),   32'h0);
        check("rst_ccount",    32'(bus.ccount),    32'd0);
        check("rst_wcount",    32'(bus.wcount),    32'd0);
        check("rst_busy",      32'(bus.busy),      32'd0);
        check("rst_game_over", 32'(bus.game_over), 32'd0);
        rst_n = 1'b1;

        // T1: asynchronous reset in the middle of SHOW
        pulse_sel(4'd0);
        pulse_sel(4'd1);
        check("t1_busy_show", 32'(bus.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t1_async_flip", 32'(bus.flip), 32'h0);
        check("t1_async_busy", 32'(bus.busy), 32'd0);
        check("t1_async_ccount", 32'(bus.ccount), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulse_sel(4'd3);
        check("t1_first_after_rst", 32'(bus.flip), 32'h0008);
        check("t1_not_busy", 32'(bus.busy), 32'd0);
        pulse_restart();
        check("t1_restart_flip", 32'(bus.flip), 32'h0);

        // T2: matching pair 0/5
        pulse_sel(4'd0);
        pulse_sel(4'd5);
        busy_cycles = 0;
        while (bus.busy && busy_cycles < 50) begin
            busy_cycles++;
            @(negedge clk);
        end
        check("t2_busy_cycles", 32'(busy_cycles), 32'd5);
        check("t2_matched", 32'(bus.matched), 32'h0021);
        check("t2_flip",    32'(bus.flip),    32'h0021);
        check("t2_ccount",  32'(bus.ccount),  32'd1);

        // T3: mismatching pair 1/2, sel during SHOW ignored
        pulse_sel(4'd1);
        pulse_sel(4'd2);
        check("t3_flip_show", 32'(bus.flip), 32'h0027);
        pulse_sel(4'd7);
        check("t3_sel_in_show", 32'(bus.flip), 32'h0027);
        wait_idle();
        check("t3_flip_hidden", 32'(bus.flip),   32'h0021);
        check("t3_wcount",      32'(bus.wcount), 32'd1);
        check("t3_ccount",      32'(bus.ccount), 32'd1);

        // T4: invalid selections
        pulse_sel(4'd3);
        pulse_sel(4'd3);
        check("t4_reselect_flip", 32'(bus.flip), 32'h0029);
        check("t4_reselect_busy", 32'(bus.busy), 32'd0);
        pulse_sel(4'd0);
        check("t4_matched_sel_flip", 32'(bus.flip), 32'h0029);
        check("t4_matched_sel_busy", 32'(bus.busy), 32'd0);

        // T6: second mismatch (3/4) hits the wrong limit only when enabled
        pulse_sel(4'd4);
        check("t6_busy", 32'(bus.busy), 32'd1);
        wait_idle();
        check("t6_wcount",    32'(bus.wcount),    32'd2);
        check("t6_game_over", 32'(bus.game_over), 32'(LimitEn));
        check("t6_flip",      32'(bus.flip),      32'h0021);
        pulse_sel(4'd6);
        check("t6_play_on", 32'(bus.flip), LimitEn ? 32'h0021 : 32'h0061);

        // T5: restart then full win
        pulse_restart();
        check("t5_restart_flip",   32'(bus.flip),      32'h0);
        check("t5_restart_wcount", 32'(bus.wcount),    32'd0);
        check("t5_restart_over",   32'(bus.game_over), 32'd0);
        for (int p = 0; p < 8; p++) begin
            pulse_sel(pa[p]);
            pulse_sel(pb[p]);
            wait_idle();
        end
        check("t5_win",       32'(bus.game_win),  32'd1);
        check("t5_over",      32'(bus.game_over), 32'd1);
        check("t5_ccount",    32'(bus.ccount),    32'd8);
        check("t5_matched",   32'(bus.matched),   32'hFFFF);
        check("t5_wcount",    32'(bus.wcount),    32'd0);

        // T5: time-out while waiting for the second card
        pulse_restart();
        check("t5_restart_win", 32'(bus.game_win), 32'd0);
        pulse_sel(4'd0);
        check("t5_pending", 32'(bus.flip), 32'h0001);
        @(negedge clk);
        bus.time_over = 1'b1;
        @(negedge clk);
        bus.time_over = 1'b0;
        check("t5_to_over", 32'(bus.game_over), 32'd1);
        check("t5_to_win",  32'(bus.game_win),  32'd0);
        check("t5_to_flip", 32'(bus.flip),      32'h0);
        pulse_sel(4'd1);
        check("t5_done_sel", 32'(bus.flip), 32'h0);
        pulse_restart();
        check("t5_final_over", 32'(bus.game_over), 32'd0);
        pulse_sel(4'd2);
        check("t5_final_first", 32'(bus.flip), 32'h0004);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
